uart_tx_fifo: RTL and testbench

Byte FIFO plus drain controller between message-producing logic (e.g. the LED command state machine) and the `uart` transmitter. Producers push bytes at up to one per clock without watching `is_transmitting`; the block pops bytes in order and hands each to the UART with a single-cycle `transmit` pulse. It waits for each byte to complete before issuing the next. This removes per-module ROM-walk and transmit handshake logic from every producer.

---
 rtl/uart_tx_fifo_pkg.sv | 18 +
 rtl/uart_tx_fifo_mem.sv | 70 +++++++
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: drain FSM encodings and
// default sizing values.
package uart_tx_fifo_pkg;

    localparam int DEFAULT_DEPTH         = 16;
    localparam int DEFAULT_START_TIMEOUT = 15;

    // Wide enough for any START_TIMEOUT in 1..255.
    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte-wide synchronous FIFO storage with pointer and occupancy tracking.
// The read port is combinational so the consumer can capture the head
// byte on the same edge it pops it.
module sync_fifo_mem
    import uart_tx_fifo_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [7:0]        din,
    input  logic              pop,
    output logic [7:0]        dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE        = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    // Flags come from the registered count, so a push while full is
    // rejected even if a pop frees an entry on the same edge.
    assign full      = (r_count == FULL_COUNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage write; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus drain controller feeding a UART transmitter. Producers
// push freely; the drain FSM pops one byte at a time, pulses transmit,
// and waits for the UART to start and finish before the next byte.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int DEPTH         = DEFAULT_DEPTH,
    parameter  int START_TIMEOUT = DEFAULT_START_TIMEOUT,
    localparam int ADDR_W        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              overflow,
    output logic              tx_timeout,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    input  logic              is_transmitting
);

    localparam logic [TIMER_W-1:0] TIMEOUT_VAL = START_TIMEOUT[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] TIMER_ONE   = 1;

    drain_state_t       r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [7:0]         r_tx_byte;
    logic               r_transmit;
    logic               r_tx_timeout;
    logic               r_overflow;

    logic               w_pop;
    logic [7:0]         w_dout;
    logic               w_full;
    logic               w_empty;
    logic [ADDR_W:0]    w_count;

    // Pop only from IDLE, so at most one byte is ever in flight.
    assign w_pop = (r_state == ST_IDLE) && !w_empty;

    sync_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = w_count;
    assign busy       = !w_empty || (r_state != ST_IDLE);
    assign overflow   = r_overflow;
    assign tx_timeout = r_tx_timeout;
    assign transmit   = r_transmit;
    assign tx_byte    = r_tx_byte;

    // Flag a push attempted while full, one cycle after the attempt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && w_full;
        end
    end

    // Drain FSM with registered transmit/timeout pulses and byte latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_tx_byte    <= 8'h00;
            r_transmit   <= 1'b0;
            r_tx_timeout <= 1'b0;
        end else begin
            r_transmit   <= 1'b0;
            r_tx_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_tx_byte <= w_dout;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_transmit <= 1'b1;
                    r_timer    <= '0;
                    r_state    <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (is_transmitting) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_timer == TIMEOUT_VAL) begin
                        // UART never started: drop the byte and move on.
                        r_tx_timeout <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!is_transmitting) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed pushes feed an expected
// byte queue; a monitor compares every transmit pulse against it while a
// simple UART model answers with is_transmitting.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int ST    = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       is_transmitting = 1'b0;
    logic       full, empty, busy, overflow, tx_timeout, transmit;
    logic [4:0] count;
    logic [7:0] tx_byte;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // UART model controls: 0 normal, 1 stall high, 2 never starts
    int uart_mode = 0;
    int uart_len  = 20;
    int rem       = 0;
    int fall_cyc  = 0;
    bit have_fall = 1'b0;
    int tx_count  = 0;
    int last_tx_cyc = 0;

    logic [7:0] exp_q[$];

    uart_tx_fifo #(.DEPTH(DEPTH), .START_TIMEOUT(ST)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .busy            (busy),
        .overflow        (overflow),
        .tx_timeout      (tx_timeout),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor first, then UART model, in one process to fix their order.
    always @(negedge clk) begin
        if (transmit) begin
            tx_count++;
            last_tx_cyc = cyc;
            $display("tx byte %02h at cycle %0d", tx_byte, cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_transmit", {24'h0, tx_byte}, 32'hFFFF_FFFF);
            end else begin
                chk("tx_byte_order", {24'h0, tx_byte}, {24'h0, exp_q.pop_front()});
            end
            chk("tx_while_uart_busy", is_transmitting, 0);
            if (have_fall) begin
                chk("gap_after_fall_ge3", (cyc - fall_cyc) >= 3, 1);
            end
            have_fall = 1'b0;
        end
        if (transmit && uart_mode != 2) begin
            is_transmitting = 1'b1;
            rem = uart_len;
        end else if (is_transmitting && uart_mode == 0) begin
            if (rem == 0) begin
                is_transmitting = 1'b0;
                fall_cyc  = cyc;
                have_fall = 1'b1;
            end else begin
                rem--;
            end
        end
    end

    // Drive one push across the next rising edge; returns at the next negedge.
    task automatic push1(input logic [7:0] b, input bit acc);
        wr_en   = 1'b1;
        wr_data = b;
        if (acc) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_tx(input int bound, input string nm);
        int n = 0;
        while (!transmit && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(nm, transmit, 1);
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(nm, busy, 0);
        chk({nm, "_uart_idle"}, is_transmitting, 0);
    endtask

    task automatic wait_timeout(input int bound, input string nm);
        int n = 0;
        while (!tx_timeout && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(nm, tx_timeout, 1);
    endtask

    logic [7:0] burst [8];
    int base;

    initial begin
        burst = '{8'h52, 8'h65, 8'h64, 8'h20, 8'h4F, 8'h4E, 8'h0D, 8'h0A};

        // Reset then idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_transmit", transmit, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", tx_timeout, 0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_count", count, 0);
        chk("idle_tx_count", tx_count, 0);

        // Single byte with exact pipeline timing
        uart_mode = 0;
        uart_len  = 20;
        push1(8'h52, 1);
        chk("single_count_after_push", count, 1);
        chk("single_busy", busy, 1);
        chk("single_no_tx_yet", transmit, 0);
        @(negedge clk);
        chk("single_popped_count", count, 0);
        chk("single_tx_byte_latched", tx_byte, 8'h52);
        chk("single_no_tx_at_pop", transmit, 0);
        @(negedge clk);
        chk("single_transmit_pulse", transmit, 1);
        @(negedge clk);
        chk("single_transmit_one_cycle", transmit, 0);
        wait_idle(200, "single_idle");
        chk("single_tx_count", tx_count, 1);

        // Burst "Red ON\r\n" back-to-back
        uart_len = 6;
        base = tx_count;
        foreach (burst[i]) push1(burst[i], 1);
        wait_idle(1000, "burst_idle");
        chk("burst_tx_count", tx_count - base, 8);
        chk("burst_queue_drained", exp_q.size(), 0);

        // Overflow while the UART is stalled
        uart_mode = 1;
        base = tx_count;
        push1(8'h21, 1);
        wait_tx(20, "stall_first_tx");
        repeat (2) @(negedge clk);
        chk("stall_count0", count, 0);
        for (int i = 0; i < DEPTH; i++) push1(8'h30 + 8'(i), 1);
        chk("fill_count16", count, 16);
        chk("fill_full", full, 1);
        chk("fill_no_overflow", overflow, 0);
        push1(8'hEE, 0);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count_kept", count, 16);
        @(negedge clk);
        chk("ovf_pulse_one_cycle", overflow, 0);
        // Release the UART so the next pop lines up with a push while full
        uart_len = 6;
        @(posedge clk);
        #1;
        uart_mode = 0;
        rem = 0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_pop_full", full, 1);
        push1(8'hDD, 0);
        chk("pop_push_ovf_pulse", overflow, 1);
        chk("pop_push_count15", count, 15);
        chk("pop_push_not_full", full, 0);
        chk("pop_push_head_byte", tx_byte, 8'h30);
        wait_idle(2000, "ovf_drain_idle");
        chk("ovf_tx_count", tx_count - base, 17);
        chk("ovf_queue_drained", exp_q.size(), 0);

        // Start timeout: UART never raises is_transmitting
        uart_mode = 2;
        base = tx_count;
        push1(8'h41, 1);
        push1(8'h42, 1);
        wait_timeout(100, "to1_seen");
        chk("to1_latency", cyc - last_tx_cyc, ST + 1);
        @(negedge clk);
        chk("to1_one_cycle", tx_timeout, 0);
        wait_timeout(100, "to2_seen");
        chk("to2_latency", cyc - last_tx_cyc, ST + 1);
        wait_idle(100, "to_idle");
        chk("to_tx_count", tx_count - base, 2);

        // Reset while in WAIT_DONE with bytes queued
        uart_mode = 0;
        uart_len  = 40;
        base = tx_count;
        for (int i = 0; i < 6; i++) push1(8'h60 + 8'(i), 1);
        @(negedge clk);
        chk("mid_count5", count, 5);
        chk("mid_uart_busy", is_transmitting, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_transmit", transmit, 0);
        chk("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (80) @(negedge clk);
        chk("mid_no_more_tx", tx_count - base, 1);
        chk("mid_final_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
